// File: rtl/alu_result_queue.sv
// ALU result selector with Z/N/C/V flag generation, illegal-opcode detection
// and a DEPTH-entry valid/ready result FIFO ahead of writeback.
module alu_result_queue #(
    parameter int N     = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       select,
    input  logic [N-1:0]     out_suma,
    input  logic             c_suma,
    input  logic             v_suma,
    input  logic [N-1:0]     out_subs,
    input  logic             c_subs,
    input  logic             v_subs,
    input  logic [2*N-1:0]   out_mult,
    input  logic [N-1:0]     out_div,
    input  logic [N-1:0]     out_mod,
    input  logic [N-1:0]     out_and,
    input  logic [N-1:0]     out_or,
    input  logic [N-1:0]     out_xor,
    input  logic [N-1:0]     out_shift_l,
    input  logic [N-1:0]     out_shift_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out,
    output logic [N-1:0]     outaux,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_MOD  = 4'b0100,
        OP_MULT = 4'b0101,
        OP_DIV  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_SHR  = 4'b1001
    } op_e;

    typedef struct packed {
        logic [N-1:0] low;
        logic [N-1:0] high;
        logic [3:0]   flags;
        logic         illegal;
    } entry_t;

    op_e          op;
    entry_t       ent;
    entry_t       mem [DEPTH];
    entry_t       last;
    entry_t       head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic         push;
    logic         pop;

    assign op = op_e'(select);

    // Entry formation; flags are {Z,N,C,V}.
    always_comb begin
        ent = '0;
        case (op)
            OP_ADD: begin
                ent.low      = out_suma;
                ent.flags[1] = c_suma;
                ent.flags[0] = v_suma;
            end
            OP_SUB: begin
                ent.low      = out_subs;
                ent.flags[1] = c_subs;
                ent.flags[0] = v_subs;
            end
            OP_AND:  ent.low = out_and;
            OP_OR:   ent.low = out_or;
            OP_MOD:  ent.low = out_mod;
            OP_MULT: begin
                ent.low      = out_mult[N-1:0];
                ent.high     = out_mult[2*N-1:N];
                ent.flags[1] = |out_mult[2*N-1:N];
            end
            OP_DIV:  ent.low = out_div;
            OP_XOR:  ent.low = out_xor;
            OP_SHL:  ent.low = out_shift_l;
            OP_SHR:  ent.low = out_shift_r;
            default: ent.illegal = 1'b1;
        endcase
        if (!ent.illegal) begin
            ent.flags[3] = (op == OP_MULT) ? (out_mult == '0) : (ent.low == '0);
            ent.flags[2] = (op == OP_MULT) ? ent.high[N-1] : ent.low[N-1];
        end
    end

    assign out_valid = (count != '0);
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ent;
    end

    // last holds the most recently popped entry so outputs stay put when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last        <= '0;
            illegal_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && ent.illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign head    = out_valid ? mem[rd_ptr] : last;
    assign out     = head.low;
    assign outaux  = head.high;
    assign flags   = head.flags;
    assign illegal = head.illegal;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (N=4, DEPTH=2, CNT_W=2).
module tb_alu_result_queue;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       select;
    logic [N-1:0]     out_suma;
    logic             c_suma;
    logic             v_suma;
    logic [N-1:0]     out_subs;
    logic             c_subs;
    logic             v_subs;
    logic [2*N-1:0]   out_mult;
    logic [N-1:0]     out_div;
    logic [N-1:0]     out_mod;
    logic [N-1:0]     out_and;
    logic [N-1:0]     out_or;
    logic [N-1:0]     out_xor;
    logic [N-1:0]     out_shift_l;
    logic [N-1:0]     out_shift_r;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out;
    logic [N-1:0]     outaux;
    logic [3:0]       flags;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int total = 0;
    int bad   = 0;

    alu_result_queue #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .select(select), .out_suma(out_suma), .c_suma(c_suma), .v_suma(v_suma),
        .out_subs(out_subs), .c_subs(c_subs), .v_subs(v_subs),
        .out_mult(out_mult), .out_div(out_div), .out_mod(out_mod),
        .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
        .out_shift_l(out_shift_l), .out_shift_r(out_shift_r),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .outaux(outaux), .flags(flags), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out, outaux, flags, illegal} per opcode 0..9
    logic [3:0]  tbl_sel [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [12:0] tbl_exp [10] = '{
        {4'h1, 4'h0, 4'b0010, 1'b0},
        {4'hF, 4'h0, 4'b0101, 1'b0},
        {4'h2, 4'h0, 4'b0000, 1'b0},
        {4'h3, 4'h0, 4'b0000, 1'b0},
        {4'h0, 4'h0, 4'b1000, 1'b0},
        {4'h4, 4'h3, 4'b0010, 1'b0},
        {4'h5, 4'h0, 4'b0000, 1'b0},
        {4'h9, 4'h0, 4'b0100, 1'b0},
        {4'hC, 4'h0, 4'b0100, 1'b0},
        {4'h6, 4'h0, 4'b0000, 1'b0}
    };

    task automatic push_one(input logic [3:0] sel);
        select   = sel;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, out, outaux, flags, illegal, illegal_cnt} !== {1'b0, 1'b1, 15'd0}) begin
            bad++;
            $display("FAIL reset_state got v=%b r=%b out=%h aux=%h fl=%b il=%b cnt=%0d expected v=0 r=1 rest 0",
                     out_valid, in_ready, out, outaux, flags, illegal, illegal_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        out_suma = 4'b1000; c_suma = 1'b0; v_suma = 1'b1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_pre_valid got %b expected 0", out_valid);
        end
        push_one(4'b0000);
        total++;
        if ({out_valid, out, outaux, flags, illegal} !== {1'b1, 4'h8, 4'h0, 4'b0101, 1'b0}) begin
            bad++;
            $display("FAIL add_result got v=%b out=%h aux=%h fl=%b il=%b expected v=1 out=8 aux=0 fl=0101 il=0",
                     out_valid, out, outaux, flags, illegal);
        end
        pop_one();
        total++;
        if ({out_valid, out, flags} !== {1'b0, 4'h8, 4'b0101}) begin
            bad++;
            $display("FAIL add_hold_after_pop got v=%b out=%h fl=%b expected v=0 out=8 fl=0101",
                     out_valid, out, flags);
        end
    endtask

    task automatic test_select_table();
        out_suma = 4'h1; c_suma = 1'b1; v_suma = 1'b0;
        out_subs = 4'hF; c_subs = 1'b0; v_subs = 1'b1;
        out_and = 4'h2; out_or = 4'h3; out_mod = 4'h0; out_mult = 8'h34;
        out_div = 4'h5; out_xor = 4'h9; out_shift_l = 4'hC; out_shift_r = 4'h6;
        for (int i = 0; i < 10; i++) begin
            push_one(tbl_sel[i]);
            total++;
            if ({out, outaux, flags, illegal} !== tbl_exp[i]) begin
                bad++;
                $display("FAIL select_%0d got %h expected %h", i, {out, outaux, flags, illegal}, tbl_exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_mult();
        logic [7:0]  prod [3] = '{8'hE1, 8'h00, 8'h08};
        logic [12:0] expv [3] = '{
            {4'h1, 4'hE, 4'b0110, 1'b0},
            {4'h0, 4'h0, 4'b1000, 1'b0},
            {4'h8, 4'h0, 4'b0000, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            out_mult = prod[i];
            push_one(4'b0101);
            total++;
            if ({out, outaux, flags, illegal} !== expv[i]) begin
                bad++;
                $display("FAIL mult_%h got %h expected %h", prod[i], {out, outaux, flags, illegal}, expv[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_illegal();
        logic [CNT_W-1:0] exp_cnt;
        out_suma = 4'h7; c_suma = 1'b1; v_suma = 1'b1;
        exp_cnt = '0;
        for (int i = 1; i <= 5; i++) begin
            push_one(4'b1100);
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            total++;
            if ({out, outaux, flags, illegal, illegal_cnt} !== {4'h0, 4'h0, 4'b0000, 1'b1, exp_cnt}) begin
                bad++;
                $display("FAIL illegal_push_%0d got out=%h aux=%h fl=%b il=%b cnt=%0d expected out=0 aux=0 fl=0000 il=1 cnt=%0d",
                         i, out, outaux, flags, illegal, illegal_cnt, exp_cnt);
            end
            pop_one();
        end
        total++;
        if (illegal_cnt !== 2'd3) begin
            bad++;
            $display("FAIL illegal_cnt_after_pops got %0d expected 3", illegal_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] expv [6] = '{
            {1'b1, 1'b1, 4'h1}, {1'b1, 1'b0, 4'h1}, {1'b1, 1'b0, 4'h1},
            {1'b1, 1'b1, 4'h2}, {1'b1, 1'b1, 4'h3}, {1'b0, 1'b1, 4'h3}
        };
        select = 4'b0000; out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) out_suma = 4'(i + 1);
            if (i == 3) out_ready = 1'b1;
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out} !== expv[i]) begin
                bad++;
                $display("FAIL backpressure_step%0d got v=%b r=%b out=%h expected %b",
                         i, out_valid, in_ready, out, expv[i]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        select = 4'b0000; out_suma = 4'h0; out_ready = 1'b0;
        push_one(4'b0000);
        for (int i = 1; i <= 10; i++) begin
            v = 4'(i);
            out_suma = v; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out} !== {1'b1, 1'b1, v}) begin
                bad++;
                $display("FAIL back_to_back_%0d got v=%b r=%b out=%h expected v=1 r=1 out=%h",
                         i, out_valid, in_ready, out, v);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({out_valid, out} !== {1'b0, 4'hA}) begin
            bad++;
            $display("FAIL back_to_back_drain got v=%b out=%h expected v=0 out=a", out_valid, out);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push_one(4'b1100);
        out_suma = 4'h5;
        push_one(4'b0000);
        total++;
        if ({out_valid, in_ready, illegal} !== 3'b101) begin
            bad++;
            $display("FAIL async_prefill got v=%b r=%b il=%b expected v=1 r=0 il=1", out_valid, in_ready, illegal);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out, outaux, flags, illegal, illegal_cnt} !== {1'b0, 1'b1, 15'd0}) begin
            bad++;
            $display("FAIL async_reset got v=%b r=%b out=%h aux=%h fl=%b il=%b cnt=%0d expected v=0 r=1 rest 0",
                     out_valid, in_ready, out, outaux, flags, illegal, illegal_cnt);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        out_suma = 4'h9;
        push_one(4'b0000);
        total++;
        if ({out_valid, out, illegal, illegal_cnt} !== {1'b1, 4'h9, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL async_after_reset got v=%b out=%h il=%b cnt=%0d expected v=1 out=9 il=0 cnt=0",
                     out_valid, out, illegal, illegal_cnt);
        end
        pop_one();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; select = 4'h0;
        out_suma = '0; c_suma = 1'b0; v_suma = 1'b0;
        out_subs = '0; c_subs = 1'b0; v_subs = 1'b0;
        out_mult = '0; out_div = '0; out_mod = '0; out_and = '0;
        out_or = '0; out_xor = '0; out_shift_l = '0; out_shift_r = '0;
        test_reset();
        test_add();
        test_select_table();
        test_mult();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Registered, flow-controlled successor to the combinational ALU result multiplexor.
- Each cycle it selects one functional-unit result by opcode and computes status flags Z/N/C/V.
- Splits the 2N-bit multiply product into low and high words, flags illegal opcodes, and buffers results in a DEPTH-entry FIFO with valid/ready on both sides.
- Sits between the ALU functional units and the register-file writeback / display logic.

Parameters:
N, 4, datapath width in bits (min 2)
DEPTH, 2, result FIFO entries (power of 2, min 2)
CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand results and select are valid this cycle
in_ready  out  1  block can accept an entry this cycle
select  in  4  opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 mod, 0101 mult, 0110 div, 0111 xor, 1000 shl, 1001 shr
out_suma  in  N  adder result
c_suma  in  1  adder carry out
v_suma  in  1  adder signed overflow
out_subs  in  N  subtractor result
c_subs  in  1  subtractor borrow out
v_subs  in  1  subtractor signed overflow
out_mult  in  2N  full product
out_div, out_mod, out_and, out_or, out_xor, out_shift_l, out_shift_r  in  N each  unit results
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
out  out  N  head result, low word
outaux  out  N  head high word (mult only, else 0)
flags  out  4  head {Z,N,C,V}
illegal  out  1  head entry came from an illegal opcode
illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes

Behaviour:
- Reset (async, active-high), all asserted immediately:
  - FIFO emptied; out_valid=0, in_ready=1.
  - out, outaux, flags, illegal = 0; illegal_cnt = 0.
- Push when in_valid & in_ready; pop when out_valid & out_ready.
- in_ready = (count < DEPTH), a registered count compare; it does not depend combinationally on out_ready.
- Entry formation on push (combinational select, registered into FIFO):
  - Opcodes 0000–1001 pick the matching result; mult gives low = out_mult[N-1:0], high = out_mult[2N-1:N].
  - All non-mult opcodes give high = 0.
  - Opcodes 1010–1111 give low = 0, high = 0, illegal = 1, flags = 0000. The old default-to-add behaviour is removed.
- Flags, legal opcodes:
  - Z = (low == 0); for mult, Z = (full 2N product == 0).
  - N = MSB of low (mult: MSB of high).
  - C: c_suma for add, c_subs for sub, out_mult high != 0 for mult, 0 otherwise.
  - V: v_suma for add, v_subs for sub, 0 otherwise.
- Latency and ordering:
  - Entry pushed at edge k is visible on the outputs after edge k when the FIFO was empty.
  - Strict in-order delivery.
- Head stability: while out_valid & !out_ready, out/outaux/flags/illegal hold stable. When out_valid=0 they hold the last popped value.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1; count unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle; the slot frees on the next cycle.
- Pointers wrap modulo DEPTH.
- illegal_cnt increments on each push with an illegal opcode and saturates at 2^CNT_W-1. It is not cleared by pops.
- Reset mid-operation discards all buffered entries; no partial output.

Test Plan:
- N=4: add 0111+0001 with c=0, v=1 -> out=1000, outaux=0000, flags=0101 (N,V), out_valid one cycle after push.
- mult, out_mult=8'hE1 -> out=0001, outaux=1110, flags: Z=0, N=1, C=1, V=0; mult with product 0 -> Z=1, C=0.
- select=1100 -> out=0, illegal=1, flags=0000, illegal_cnt 0->1; with CNT_W=2 push 5 illegals -> cnt saturates at 3.
- Hold out_ready=0 and push 3 entries, DEPTH=2 -> in_ready drops after 2 pushes and the head stays stable. Then raise out_ready -> entries emerge in order and in_ready returns the cycle after the first pop.
- count=1 with push and pop in the same cycle, repeated 10 cycles -> count stays 1, no loss or duplication, pointer wrap exercised.
- Assert rst asynchronously mid-stream with 2 entries buffered -> out_valid=0 and illegal_cnt=0 immediately without a clock edge; the next push emerges correctly.
